timer_digit_register: RTL and testbench

- Downstream of the keypad priority encoder. Consumes its 4-bit digit code and active-low key-present strobe `loadn`.
- Synchronises and debounces each key press, then shifts the accepted decimal digit into a 3-digit BCD time entry (M:SS).
- Feeds the countdown timer and the display driver with the entered minutes, tens-of-seconds and units-of-seconds digits.

---
 rtl/timer_digit_register.sv | 174 +++++++++++++++++
 tb/tb_timer_digit_register.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/timer_digit_register.sv
// Keypad digit entry for the microwave timer: synchronises and debounces the
// encoder strobe, then shifts accepted decimal digits into an M:SS BCD entry.
module timer_digit_register #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] saida_cod,
    input  logic       loadn,
    input  logic       enablen,
    input  logic       clearn,
    output logic [3:0] dig_min,
    output logic [3:0] dig_seg_dez,
    output logic [3:0] dig_seg_uni,
    output logic       key_pulse,
    output logic       tempo_valido
);

    localparam int unsigned CODE_W = 4;
    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CODE_W-1:0] CODE_MAXD = CODE_W'(9);
    localparam logic [CODE_W-1:0] DEZ_MAX   = CODE_W'(5);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_LOAD,
        S_WAIT_RELEASE
    } state_t;

    logic [SYNC_STAGES-1:0] r_ls_sync;
    logic [CODE_W-1:0]      r_cs_sync [SYNC_STAGES];
    logic                   w_ls;
    logic [CODE_W-1:0]      w_cs;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [CODE_W-1:0] r_code;
    logic [CODE_W-1:0] w_code_nxt;

    logic [CODE_W-1:0] r_dig_min;
    logic [CODE_W-1:0] r_dig_seg_dez;
    logic [CODE_W-1:0] r_dig_seg_uni;
    logic [CODE_W-1:0] w_dig_min_nxt;
    logic [CODE_W-1:0] w_dig_seg_dez_nxt;
    logic [CODE_W-1:0] w_dig_seg_uni_nxt;
    logic              w_load_ok;
    logic              w_entry_nonzero;

    // Input synchroniser; idle values are key released and code 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ls_sync <= '1;
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                r_cs_sync[i] <= '0;
            end
        end else begin
            r_ls_sync    <= {r_ls_sync[SYNC_STAGES-2:0], loadn};
            r_cs_sync[0] <= saida_cod;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                r_cs_sync[i] <= r_cs_sync[i-1];
            end
        end
    end

    assign w_ls      = r_ls_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // State, debounce counter, captured code and digit registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_code        <= '0;
            r_dig_min     <= '0;
            r_dig_seg_dez <= '0;
            r_dig_seg_uni <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_code        <= w_code_nxt;
            r_dig_min     <= w_dig_min_nxt;
            r_dig_seg_dez <= w_dig_seg_dez_nxt;
            r_dig_seg_uni <= w_dig_seg_uni_nxt;
        end
    end

    // Next-state, counter and digit-shift logic; enablen high aborts any press.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_code_nxt        = r_code;
        w_dig_min_nxt     = r_dig_min;
        w_dig_seg_dez_nxt = r_dig_seg_dez;
        w_dig_seg_uni_nxt = r_dig_seg_uni;
        w_load_ok         = 1'b0;

        if (enablen) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_ls) begin
                        w_state_nxt = S_DEBOUNCE;
                        w_cnt_nxt   = CNT_W'(1);
                        w_code_nxt  = w_cs;
                    end
                end
                S_DEBOUNCE: begin
                    if (w_ls) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (w_cs != r_code) begin
                        w_cnt_nxt  = CNT_W'(1);
                        w_code_nxt = w_cs;
                    end else if (r_cnt >= CNT_LAST) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                S_LOAD: begin
                    w_state_nxt = S_WAIT_RELEASE;
                    w_cnt_nxt   = '0;
                    w_load_ok   = (r_code <= CODE_MAXD);
                end
                S_WAIT_RELEASE: begin
                    if (!w_ls) begin
                        w_cnt_nxt = '0;
                    end else if (r_cnt >= CNT_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        if (w_load_ok) begin
            w_dig_min_nxt     = r_dig_seg_dez;
            w_dig_seg_dez_nxt = r_dig_seg_uni;
            w_dig_seg_uni_nxt = r_code;
        end

        // Clear wins over a shift landing on the same edge.
        if (!clearn) begin
            w_dig_min_nxt     = '0;
            w_dig_seg_dez_nxt = '0;
            w_dig_seg_uni_nxt = '0;
        end
    end

    assign key_pulse       = w_load_ok & clearn;
    assign w_entry_nonzero = (r_dig_min != '0) | (r_dig_seg_dez != '0) | (r_dig_seg_uni != '0);
    assign tempo_valido    = w_entry_nonzero & (r_dig_seg_dez <= DEZ_MAX);

    assign dig_min     = r_dig_min;
    assign dig_seg_dez = r_dig_seg_dez;
    assign dig_seg_uni = r_dig_seg_uni;

endmodule

// File: tb/tb_timer_digit_register.sv
// Scoreboard bench for timer_digit_register: expected digits are queued per
// press and compared one cycle after each key_pulse.
module tb_timer_digit_register;

    logic       clk;
    logic       rstn;
    logic [3:0] saida_cod;
    logic       loadn;
    logic       enablen;
    logic       clearn;
    logic [3:0] dig_min;
    logic [3:0] dig_seg_dez;
    logic [3:0] dig_seg_uni;
    logic       key_pulse;
    logic       tempo_valido;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pulse_cnt = 0;
    int          last_pulse_cyc = 0;
    int          t0 = 0;
    logic [11:0] m_dig = '0;
    logic [11:0] sb_q[$];
    logic [11:0] pend = '0;
    bit          cmp_pending = 0;

    timer_digit_register #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .saida_cod   (saida_cod),
        .loadn       (loadn),
        .enablen     (enablen),
        .clearn      (clearn),
        .dig_min     (dig_min),
        .dig_seg_dez (dig_seg_dez),
        .dig_seg_uni (dig_seg_uni),
        .key_pulse   (key_pulse),
        .tempo_valido(tempo_valido)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int tv_model(input logic [11:0] d);
        return int'((d != 12'h000) && (d[7:4] <= 4'd5));
    endfunction

    function automatic logic [11:0] dut_dig();
        return {dig_min, dig_seg_dez, dig_seg_uni};
    endfunction

    // Output monitor: each pulse pops one expectation, checked after the shift edge.
    always @(negedge clk) begin
        if (cmp_pending) begin
            chk_val("digits", int'(dut_dig()), int'(pend));
            chk_val("tempo_valido", int'(tempo_valido), tv_model(pend));
            cmp_pending = 0;
        end
        if (key_pulse === 1'b1) begin
            pulse_cnt++;
            last_pulse_cyc = cyc;
            chk_val("pulse_has_exp", int'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                pend        = sb_q.pop_front();
                cmp_pending = 1;
            end
        end
    end

    task automatic press(input logic [3:0] code, input int hold, input int rel,
                         input bit exp_shift, input int clr_at,
                         input int chg_at, input logic [3:0] chg_code);
        int         p0;
        logic [3:0] fin;
        p0  = pulse_cnt;
        fin = (chg_at > 0) ? chg_code : code;
        if (exp_shift) begin
            m_dig = {m_dig[7:0], fin};
            sb_q.push_back(m_dig);
        end
        saida_cod = code;
        loadn     = 1'b0;
        t0        = cyc;
        for (int i = 1; i <= hold; i++) begin
            @(posedge clk); #1;
            if (i == chg_at) saida_cod = chg_code;
            clearn = (i == clr_at) ? 1'b0 : 1'b1;
            if (i == clr_at) m_dig = '0;
        end
        loadn     = 1'b1;
        saida_cod = 4'd0;
        clearn    = 1'b1;
        repeat (rel) begin
            @(posedge clk); #1;
        end
        chk_val("npulse", pulse_cnt - p0, exp_shift ? 1 : 0);
    endtask

    task automatic clear_entry();
        clearn = 1'b0;
        m_dig  = '0;
        @(posedge clk); #1;
        clearn = 1'b1;
        chk_val("clear_digits", int'(dut_dig()), int'(m_dig));
    endtask

    initial begin
        rstn      = 1'b0;
        loadn     = 1'b0;
        saida_cod = 4'd5;
        enablen   = 1'b0;
        clearn    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_val("rst_digits", int'(dut_dig()), 0);
        chk_val("rst_pulse", int'(key_pulse), 0);
        chk_val("rst_tv", int'(tempo_valido), 0);

        // Key held through reset release is debounced as one new press.
        m_dig = 12'h005;
        sb_q.push_back(m_dig);
        rstn = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        loadn = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk_val("rst_held_npulse", pulse_cnt, 1);

        clear_entry();
        press(4'd1, 10, 10, 1, 0, 0, 4'd0);
        press(4'd3, 10, 10, 1, 0, 0, 4'd0);
        press(4'd0, 10, 10, 1, 0, 0, 4'd0);
        chk_val("entry_130", int'(dut_dig()), 12'h130);

        press(4'd7, 10, 10, 1, 0, 0, 4'd0);
        chk_val("entry_307", int'(dut_dig()), 12'h307);

        // Glitch just one sample short of acceptance.
        press(4'd6, 3, 10, 0, 0, 0, 4'd0);
        chk_val("short_hold", int'(dut_dig()), int'(m_dig));

        press(4'd2, 20, 10, 1, 0, 0, 4'd0);
        chk_val("pulse_cyc", last_pulse_cyc - t0, 6);

        press(4'd12, 10, 10, 0, 0, 0, 4'd0);
        chk_val("invalid_hold", int'(dut_dig()), int'(m_dig));

        clear_entry();
        press(4'd7, 10, 10, 1, 0, 0, 4'd0);
        press(4'd5, 10, 10, 1, 0, 0, 4'd0);
        chk_val("entry_075", int'(dut_dig()), 12'h075);
        chk_val("tv_075", int'(tempo_valido), 0);

        enablen = 1'b1;
        press(4'd4, 10, 10, 0, 0, 0, 4'd0);
        enablen = 1'b0;
        chk_val("enablen_hold", int'(dut_dig()), int'(m_dig));

        press(4'd9, 10, 10, 0, 6, 0, 4'd0);
        chk_val("clear_in_load", int'(dut_dig()), 0);

        press(4'd2, 12, 10, 1, 0, 2, 4'd8);
        chk_val("code_change", int'(dut_dig()), 12'h008);

        repeat (3) @(posedge clk);
        #1;
        chk_val("sb_empty", sb_q.size(), 0);
        chk_val("final_digits", int'(dut_dig()), int'(m_dig));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
